// File: rtl/dp_pkg.sv
// Shared decode constants and enums for the two-stage pipe_datapath core.
package dp_pkg;

  // Major opcodes understood by the datapath
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3 encodings (ALU ops share them between R and I forms)
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;

  // funct7 encodings for R-type
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_e;

  typedef enum logic {
    ST_IDLE,
    ST_LOAD_WAIT
  } dp_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU; arithmetic wraps at XLEN bits, SLT compares signed.
module alu
  import dp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_ctrl_e        op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  y
);

  // Select the operation result
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y[0] = ($signed(a) < $signed(b));
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage (EX, WB) integer datapath with a blocking single-outstanding load.
// Build option: define PIPE_DATAPATH_FWD_EN to forward the WB result into EX
// instead of stalling one cycle on a back-to-back register dependency.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_IDLE      | executing the instruction at pc; may issue a load request
// ST_LOAD_WAIT | load issued, pc held, WB bubbles until dmem_rvalid
module pipe_datapath
  import dp_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [XLEN-1:0]   pc,
  input  logic [31:0]       instr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_rvalid,
  output logic [XLEN-1:0]   alu_result
);

  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  dp_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             wb_we_q, wb_we_d;
  logic [IDXW-1:0]  wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_result_q, wb_result_d;
  logic [IDXW-1:0]  ld_rd_q, ld_rd_d;

  logic [XLEN-1:0]  rf_q [NREGS];

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [IDXW-1:0]  rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0]  imm_i, imm_s;

  logic             is_alu, is_imm, is_lw, is_sw;
  logic             uses_rs1, uses_rs2;
  alu_ctrl_e        alu_op;

  logic [XLEN-1:0]  rf_rs1, rf_rs2;
  logic [XLEN-1:0]  op_a, op_b, alu_b, alu_y;
  logic             hz_rs1, hz_rs2, stall_hz;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign rd_idx  = instr[7 +: IDXW];
  assign rs1_idx = instr[15 +: IDXW];
  assign rs2_idx = instr[20 +: IDXW];
  assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

  // Decode the instruction class and ALU operation; unknown encodings stay NOP
  always_comb begin
    is_alu = 1'b0;
    is_imm = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    alu_op = ALU_ADD;
    case (opcode)
      OPC_R: begin
        is_alu = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD_SUB}: alu_op = ALU_ADD;
          {F7_SUB,  F3_ADD_SUB}: alu_op = ALU_SUB;
          {F7_BASE, F3_SLT}:     alu_op = ALU_SLT;
          {F7_BASE, F3_OR}:      alu_op = ALU_OR;
          {F7_BASE, F3_AND}:     alu_op = ALU_AND;
          default:               is_alu = 1'b0;
        endcase
      end
      OPC_I: begin
        is_alu = 1'b1;
        is_imm = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu_op = ALU_ADD;
          F3_SLT:     alu_op = ALU_SLT;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default: begin
            is_alu = 1'b0;
            is_imm = 1'b0;
          end
        endcase
      end
      OPC_LOAD:  is_lw = (funct3 == F3_WORD);
      OPC_STORE: is_sw = (funct3 == F3_WORD);
      default: ;
    endcase
  end

  // An I-type's rs2 field is immediate bits, so only real operands can hazard
  assign uses_rs1 = is_alu | is_lw | is_sw;
  assign uses_rs2 = (is_alu & ~is_imm) | is_sw;

  assign rf_rs1 = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
  assign rf_rs2 = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

  // WB has not reached the register file yet, so its target is the only hazard
  assign hz_rs1 = wb_we_q && uses_rs1 && (wb_rd_q == rs1_idx) && (rs1_idx != '0);
  assign hz_rs2 = wb_we_q && uses_rs2 && (wb_rd_q == rs2_idx) && (rs2_idx != '0);

`ifdef PIPE_DATAPATH_FWD_EN
  assign op_a     = hz_rs1 ? wb_result_q : rf_rs1;
  assign op_b     = hz_rs2 ? wb_result_q : rf_rs2;
  assign stall_hz = 1'b0;
`else
  assign op_a     = rf_rs1;
  assign op_b     = rf_rs2;
  assign stall_hz = hz_rs1 | hz_rs2;
`endif

  // Loads and stores reuse the ALU adder for address generation
  assign alu_b = is_sw ? imm_s : ((is_imm | is_lw) ? imm_i : op_b);

  alu #(.XLEN(XLEN)) u_alu (
    .op (alu_op),
    .a  (op_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Next-state, pc, WB and memory-request logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_result_d = wb_result_q;
    ld_rd_d     = ld_rd_q;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stall_hz) begin
          if (is_lw) begin
            dmem_req = 1'b1;
            ld_rd_d  = rd_idx;
            state_d  = ST_LOAD_WAIT;
          end else begin
            pc_d = pc_q + XLEN'(4);
            if (is_sw) begin
              dmem_req = 1'b1;
              dmem_we  = 1'b1;
            end
            if (is_alu) begin
              wb_we_d     = (rd_idx != '0);
              wb_rd_d     = rd_idx;
              wb_result_d = alu_y;
            end
          end
        end
      end
      ST_LOAD_WAIT: begin
        if (dmem_rvalid) begin
          wb_we_d     = (ld_rd_q != '0);
          wb_rd_d     = ld_rd_q;
          wb_result_d = dmem_rdata;
          pc_d        = pc_q + XLEN'(4);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!reset_n) begin
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  // Pipeline and FSM registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_result_q <= '0;
      ld_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_result_q <= wb_result_d;
      ld_rd_q     <= ld_rd_d;
    end
  end

  // Register file commit at the edge that ends WB; contents are never reset
  always_ff @(posedge clk) begin
    if (reset_n && wb_we_q) begin
      rf_q[wb_rd_q] <= wb_result_q;
    end
  end

  assign pc         = pc_q;
  assign alu_result = wb_result_q;
  assign dmem_addr  = alu_y;
  assign dmem_wdata = op_b;

endmodule

// File: tb/tb_pipe_datapath.sv
// Self-checking bench for pipe_datapath: directed scenarios plus random
// programs checked against an architectural instruction-level model.
module tb_pipe_datapath;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_rvalid;
  logic [31:0] alu_result;

  logic [31:0] imem [256];
  int n_tests = 0;
  int n_fail  = 0;

`ifdef PIPE_DATAPATH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  assign instr = imem[pc[9:2]];

  pipe_datapath #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc          (pc),
    .instr       (instr),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid),
    .alu_result  (alu_result)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input int rd, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), f3, 5'(rd), opc};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(7'b0010011, 3'b000, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
    return enc_i(7'b0000011, 3'b010, rd, rs1, imm);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;
  endtask

  task automatic hold_reset();
    reset_n     = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    hold_reset();
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_tests++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL reset_alu_result: got %h expected 0", alu_result); end
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_req: got %b expected 0", dmem_req); end
    n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_we: got %b expected 0", dmem_we); end
    clear_imem();
    imem[0] = addi(1, 0, 5);
    reset_n = 1'b1;
    tick();
    n_tests++; if (pc !== 32'h4) begin n_fail++; $display("FAIL first_pc: got %h expected %h", pc, 32'h4); end
    n_tests++; if (alu_result !== 32'd5) begin n_fail++; $display("FAIL first_alu_result: got %h expected %h", alu_result, 32'd5); end
    tick();
    n_tests++; if (dut.rf_q[1] !== 32'd5) begin n_fail++; $display("FAIL first_x1: got %h expected %h", dut.rf_q[1], 32'd5); end
  endtask

  task automatic test_fwd();
    logic [31:0] exp_pc;
    hold_reset();
    clear_imem();
    imem[0] = addi(2, 0, 99);
    imem[1] = addi(1, 0, 7);
    imem[2] = enc_r(7'h00, 1, 1, 3'b000, 2);
    reset_n = 1'b1;
    repeat (3) tick();
    exp_pc = FWD ? 32'd12 : 32'd8;
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL dep_pc: got %h expected %h", pc, exp_pc); end
    repeat (4) tick();
    n_tests++; if (dut.rf_q[1] !== 32'd7) begin n_fail++; $display("FAIL dep_x1: got %h expected %h", dut.rf_q[1], 32'd7); end
    n_tests++; if (dut.rf_q[2] !== 32'd14) begin n_fail++; $display("FAIL dep_x2: got %h expected %h", dut.rf_q[2], 32'd14); end
  endtask

  task automatic test_load();
    hold_reset();
    clear_imem();
    imem[0] = addi(3, 0, 1);
    imem[1] = addi(1, 0, 32'h100);
    imem[3] = lw(3, 1, 8);
    reset_n = 1'b1;
    repeat (3) tick();
    n_tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL lw_req: got req=%b we=%b expected req=1 we=0", dmem_req, dmem_we); end
    n_tests++; if (dmem_addr !== 32'h108) begin n_fail++; $display("FAIL lw_addr: got %h expected %h", dmem_addr, 32'h108); end
    // rvalid in the request cycle must be ignored
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (pc !== 32'd12) begin n_fail++; $display("FAIL lw_hold_pc%0d: got %h expected %h", c, pc, 32'd12); end
      tick();
      dmem_rvalid = 1'b0;
      n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lw_wait_req%0d: got %b expected 0", c, dmem_req); end
    end
    n_tests++; if (pc !== 32'd12) begin n_fail++; $display("FAIL lw_hold_pc3: got %h expected %h", pc, 32'd12); end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    tick();
    dmem_rvalid = 1'b0;
    n_tests++; if (pc !== 32'd16) begin n_fail++; $display("FAIL lw_resume_pc: got %h expected %h", pc, 32'd16); end
    n_tests++; if (alu_result !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_wb: got %h expected %h", alu_result, 32'hDEADBEEF); end
    tick();
    n_tests++; if (dut.rf_q[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_x3: got %h expected %h", dut.rf_q[3], 32'hDEADBEEF); end
  endtask

  task automatic test_store();
    hold_reset();
    clear_imem();
    imem[0] = addi(2, 0, 14);
    imem[2] = enc_s(2, 0, 4);
    reset_n = 1'b1;
    repeat (2) tick();
    n_tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin n_fail++; $display("FAIL sw_req: got req=%b we=%b expected req=1 we=1", dmem_req, dmem_we); end
    n_tests++; if (dmem_addr !== 32'd4) begin n_fail++; $display("FAIL sw_addr: got %h expected %h", dmem_addr, 32'd4); end
    n_tests++; if (dmem_wdata !== 32'd14) begin n_fail++; $display("FAIL sw_wdata: got %h expected %h", dmem_wdata, 32'd14); end
    tick();
    n_tests++; if (pc !== 32'd12) begin n_fail++; $display("FAIL sw_pc: got %h expected %h", pc, 32'd12); end
    n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL sw_one_cycle: got %b expected 0", dmem_req); end
  endtask

  task automatic test_reset_in_load();
    hold_reset();
    clear_imem();
    imem[0] = addi(7, 0, 32'h55);
    imem[2] = lw(7, 0, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    n_tests++; if (pc !== 32'd8) begin n_fail++; $display("FAIL rl_wait_pc: got %h expected %h", pc, 32'd8); end
    reset_n = 1'b0;
    tick();
    tick();
    n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rl_reset_pc: got %h expected 0", pc); end
    clear_imem();
    reset_n     = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBAD0BAD0;
    tick();
    n_tests++; if (pc !== 32'd4) begin n_fail++; $display("FAIL rl_idle_pc: got %h expected %h", pc, 32'd4); end
    tick();
    dmem_rvalid = 1'b0;
    tick();
    n_tests++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL rl_wb: got %h expected 0", alu_result); end
    n_tests++; if (dut.rf_q[7] !== 32'h55) begin n_fail++; $display("FAIL rl_x7: got %h expected %h", dut.rf_q[7], 32'h55); end
  endtask

  task automatic test_x0_slt();
    logic [31:0] exp_pc;
    hold_reset();
    clear_imem();
    imem[0] = addi(4, 0, 3);
    imem[1] = addi(6, 0, 7);
    imem[2] = addi(0, 0, 9);
    imem[3] = enc_r(7'h00, 0, 0, 3'b000, 4);
    imem[4] = addi(5, 0, -1);
    imem[5] = enc_i(7'b0010011, 3'b010, 6, 5, 0);
    reset_n = 1'b1;
    repeat (12) tick();
    exp_pc = FWD ? 32'd48 : 32'd44;
    n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL x0_pc: got %h expected %h", pc, exp_pc); end
    n_tests++; if (dut.rf_q[4] !== 32'h0) begin n_fail++; $display("FAIL x0_x4: got %h expected 0", dut.rf_q[4]); end
    n_tests++; if (dut.rf_q[5] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL x0_x5: got %h expected ffffffff", dut.rf_q[5]); end
    n_tests++; if (dut.rf_q[6] !== 32'h1) begin n_fail++; $display("FAIL slti_x6: got %h expected 1", dut.rf_q[6]); end
  endtask

  // Random program against an instruction-level model: register results,
  // memory request stream and total cycle count (stalls, load latency).
  task automatic test_random(input int n_ins);
    logic [31:0] m_rf [8];
    logic [31:0] st_addr_q[$], st_data_q[$], ld_addr_q[$], ld_data_q[$];
    int lat_q[$];
    int exp_cycles, prev_wr, cycles, ld_cnt;
    logic [31:0] end_pc, a, b, simm, res, ins, exp_a, exp_d;
    int kind, rd, rs1, rs2, imm, lat;
    bit uses1, uses2, wr;

    hold_reset();
    clear_imem();
    m_rf[0] = 32'h0;
    exp_cycles = 0;
    prev_wr = 0;
    for (int r = 1; r < 8; r++) begin
      imm = int'($urandom_range(0, 4095)) - 2048;
      imem[r-1] = addi(r, 0, imm);
      m_rf[r] = 32'(imm);
      exp_cycles++;
      prev_wr = r;
    end
    for (int k = 0; k < n_ins; k++) begin
      kind = int'($urandom_range(0, 11));
      rd   = int'($urandom_range(0, 7));
      rs1  = int'($urandom_range(0, 7));
      rs2  = int'($urandom_range(0, 7));
      imm  = int'($urandom_range(0, 4095)) - 2048;
      a = m_rf[rs1];
      b = m_rf[rs2];
      simm = 32'(imm);
      uses1 = 1'b1; uses2 = 1'b0; wr = 1'b1; lat = 0; res = 32'h0; ins = 32'h0;
      case (kind)
        0: begin ins = enc_r(7'h00, rs2, rs1, 3'b000, rd); res = a + b; uses2 = 1'b1; end
        1: begin ins = enc_r(7'h20, rs2, rs1, 3'b000, rd); res = a - b; uses2 = 1'b1; end
        2: begin ins = enc_r(7'h00, rs2, rs1, 3'b111, rd); res = a & b; uses2 = 1'b1; end
        3: begin ins = enc_r(7'h00, rs2, rs1, 3'b110, rd); res = a | b; uses2 = 1'b1; end
        4: begin ins = enc_r(7'h00, rs2, rs1, 3'b010, rd); res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; uses2 = 1'b1; end
        5: begin ins = enc_i(7'b0010011, 3'b000, rd, rs1, imm); res = a + simm; end
        6: begin ins = enc_i(7'b0010011, 3'b111, rd, rs1, imm); res = a & simm; end
        7: begin ins = enc_i(7'b0010011, 3'b110, rd, rs1, imm); res = a | simm; end
        8: begin ins = enc_i(7'b0010011, 3'b010, rd, rs1, imm); res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
        9: begin
          ins = lw(rd, rs1, imm);
          res = $urandom;
          lat = int'($urandom_range(1, 3));
          ld_addr_q.push_back(a + simm);
          ld_data_q.push_back(res);
          lat_q.push_back(lat);
        end
        10: begin
          ins = enc_s(rs2, rs1, imm);
          uses2 = 1'b1; wr = 1'b0;
          st_addr_q.push_back(a + simm);
          st_data_q.push_back(b);
        end
        default: begin ins = 32'h0; uses1 = 1'b0; wr = 1'b0; end
      endcase
      if (!FWD && prev_wr != 0 && ((uses1 && rs1 == prev_wr) || (uses2 && rs2 == prev_wr)))
        exp_cycles++;
      exp_cycles += 1 + lat;
      if (wr && rd != 0) m_rf[rd] = res;
      prev_wr = (wr && rd != 0) ? rd : 0;
      imem[7+k] = ins;
    end
    end_pc = 32'((7 + n_ins) * 4);

    reset_n = 1'b1;
    cycles = 0;
    ld_cnt = 0;
    while (pc !== end_pc && cycles < 1000) begin
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (ld_cnt > 0) begin
        ld_cnt--;
        if (ld_cnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = (ld_data_q.size() > 0) ? ld_data_q.pop_front() : 32'h0;
        end
      end else begin
        if (dmem_req === 1'b1) begin
          if (dmem_we === 1'b1) begin
            exp_a = (st_addr_q.size() > 0) ? st_addr_q.pop_front() : 32'hxxxxxxxx;
            exp_d = (st_data_q.size() > 0) ? st_data_q.pop_front() : 32'hxxxxxxxx;
            n_tests++;
            if (dmem_addr !== exp_a || dmem_wdata !== exp_d) begin
              n_fail++;
              $display("FAIL rand_store: got addr=%h data=%h expected addr=%h data=%h", dmem_addr, dmem_wdata, exp_a, exp_d);
            end
          end else begin
            exp_a = (ld_addr_q.size() > 0) ? ld_addr_q.pop_front() : 32'hxxxxxxxx;
            ld_cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
            n_tests++;
            if (dmem_addr !== exp_a) begin
              n_fail++;
              $display("FAIL rand_load_addr: got %h expected %h", dmem_addr, exp_a);
            end
          end
        end
        if ($urandom_range(0, 3) == 0) dmem_rvalid = 1'b1;
      end
      tick();
      cycles++;
    end
    dmem_rvalid = 1'b0;
    n_tests++;
    if (cycles != exp_cycles) begin
      n_fail++;
      $display("FAIL rand_cycles: got %0d expected %0d", cycles, exp_cycles);
    end
    n_tests++;
    if (st_addr_q.size() != 0 || ld_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_mem_count: got %0d stores %0d loads left, expected 0", st_addr_q.size(), ld_addr_q.size());
    end
    tick();
    tick();
    for (int r = 1; r < 8; r++) begin
      n_tests++;
      if (dut.rf_q[r] !== m_rf[r]) begin
        n_fail++;
        $display("FAIL rand_x%0d: got %h expected %h", r, dut.rf_q[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    clear_imem();
    test_reset();
    test_fwd();
    test_load();
    test_store();
    test_reset_in_load();
    test_x0_slt();
    for (int i = 0; i < 4; i++) test_random(40);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register width.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of two, 2..32).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded at reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port pc, output, XLEN, the instruction fetch address.
REQ-007 SHALL have port instr, input, 32, the instruction at pc, valid in the same cycle.
REQ-008 SHALL have port dmem_req, output, 1, the data-memory request strobe.
REQ-009 SHALL have port dmem_we, output, 1, store-request qualifier.
REQ-010 SHALL have ports dmem_addr, output, XLEN and dmem_wdata, output, XLEN.
REQ-011 SHALL have ports dmem_rdata, input, XLEN and dmem_rvalid, input, 1, the load return.
REQ-012 SHALL have port alu_result, output, XLEN, the registered writeback-stage result.

Function
REQ-013 SHALL use two stages: EX (decode, operand read, ALU, memory request) and WB (rd, result and we registers; register-file write on the edge that ends WB).
REQ-014 SHALL decode R-type (0110011) ADD/SUB/AND/OR/SLT, I-type (0010011) ADDI/ANDI/ORI/SLTI, LW (0000011) and SW (0100011); any other encoding is a NOP with no write and no request.
REQ-015 SHALL sign-extend I and S immediates to XLEN; arithmetic wraps modulo 2^XLEN; SLT/SLTI compare signed.
REQ-016 SHALL read register x0 as zero and discard writes to it.
REQ-017 SHALL use rd/rs indices modulo NREGS (low log2(NREGS) bits).
REQ-018 SHALL advance pc by 4 every cycle unless stalled, wrapping modulo 2^XLEN.
REQ-019 SHALL use FSM states IDLE and LOAD_WAIT.
REQ-020 In IDLE, for LW: assert dmem_req=1, dmem_we=0 and dmem_addr=rs1+imm for exactly one cycle, hold pc, and go to LOAD_WAIT.
REQ-021 In LOAD_WAIT: hold pc, keep dmem_req=0, and insert a WB bubble each cycle; on dmem_rvalid=1, load dmem_rdata into WB for rd, advance pc and return to IDLE.
REQ-022 SHALL sample dmem_rvalid only in LOAD_WAIT, ignoring it in IDLE; the earliest return is the cycle after the request.
REQ-023 SW SHALL assert dmem_req=1, dmem_we=1, dmem_addr=rs1+imm and dmem_wdata=rs2 for one cycle, with no stall and no register write.
REQ-024 Non-load instructions SHALL complete EX in one cycle; results reach WB one cycle later.

Reset
REQ-025 While reset_n=0 at a rising edge: pc=RESET_PC, state=IDLE, WB we=0, alu_result=0, dmem_req=0, dmem_we=0.
REQ-026 Reset in LOAD_WAIT SHALL abandon the load; a later dmem_rvalid SHALL be ignored.
REQ-027 Register-file contents SHALL NOT be reset, except that x0 reads zero.

Configuration
REQ-028 Macro PIPE_DATAPATH_FWD_EN defined: when WB.we=1, WB.rd equals EX rs1/rs2 and that index is non-zero, the EX operand SHALL be the WB result, with no stall.
REQ-029 Macro PIPE_DATAPATH_FWD_EN undefined: that same hazard SHALL stall EX one cycle (pc held, WB bubble) and then re-read the register file.

Structure
REQ-030 Package dp_pkg SHALL hold opcode constants, the funct3/funct7 encodings, the alu_ctrl enum and the FSM state enum.
REQ-031 SHALL instantiate the existing alu sub-module, widened to XLEN; the register file SHALL be inline.

Verification
REQ-032 Reset then ADDI x1,x0,5: pc=RESET_PC+4 after one cycle; alu_result=5 in WB; x1=5.
REQ-033 ADDI x1,x0,7 then ADD x2,x1,x1: with FWD_EN, x2=14 and pc advances every cycle; without it, 14 with one stall cycle.
REQ-034 LW x3,8(x1) with x1=0x100: dmem_req=1 with addr 0x108; rvalid after 3 cycles with rdata 0xDEADBEEF: pc held 4 cycles, x3=0xDEADBEEF.
REQ-035 SW x2,4(x0) with x2=14: one-cycle dmem_req=1, dmem_we=1, addr 4, wdata 14; no stall.
REQ-036 Reset_n=0 during LOAD_WAIT, then rvalid=1: state IDLE, pc=RESET_PC, no register written.
REQ-037 ADDI x0,x0,9 then ADD x4,x0,x0: x4=0; ADDI x5,x0,-1 then SLTI x6,x5,0: x6=1.
